// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: shared MIPS encoding constants for the program-load path.
// Holds the opcode and funct field values of the supported subset, the
// request-kind codes the loader accepts, and the encoder FSM state type.
// The PAD state only exists when MIPS_ENC_NOP_PAD_EN is defined.
package mips_isa_pkg;

    // Primary opcodes, bits [31:26] of the instruction word
    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    // R-type function codes, bits [5:0] of the instruction word
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // Request kinds; every code from 9 to 15 is rejected as illegal
    localparam logic [3:0] KIND_ADD = 4'd0;
    localparam logic [3:0] KIND_SUB = 4'd1;
    localparam logic [3:0] KIND_AND = 4'd2;
    localparam logic [3:0] KIND_OR  = 4'd3;
    localparam logic [3:0] KIND_SLT = 4'd4;
    localparam logic [3:0] KIND_LW  = 4'd5;
    localparam logic [3:0] KIND_SW  = 4'd6;
    localparam logic [3:0] KIND_BEQ = 4'd7;
    localparam logic [3:0] KIND_J   = 4'd8;

    // Loader session states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1
`ifdef MIPS_ENC_NOP_PAD_EN
        ,
        ST_PAD  = 2'd2
`endif
    } enc_state_e;

endpackage

// File: rtl/mips_enc_word.sv
// mips_enc_word: purely combinational instruction packer.
// Takes a request kind plus register, immediate and target fields and
// produces the 32-bit MIPS word. Kinds outside the supported subset give
// an all-zero word with illegal_o raised so the caller can skip the write.
module mips_enc_word
    import mips_isa_pkg::*;
(
    input  logic [3:0]  kind_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    // Pack the fields according to the instruction format of each kind
    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (kind_i)
            KIND_ADD: word_o = {OP_R, rs_i, rt_i, rd_i, 5'b00000, FN_ADD};
            KIND_SUB: word_o = {OP_R, rs_i, rt_i, rd_i, 5'b00000, FN_SUB};
            KIND_AND: word_o = {OP_R, rs_i, rt_i, rd_i, 5'b00000, FN_AND};
            KIND_OR:  word_o = {OP_R, rs_i, rt_i, rd_i, 5'b00000, FN_OR};
            KIND_SLT: word_o = {OP_R, rs_i, rt_i, rd_i, 5'b00000, FN_SLT};
            KIND_LW:  word_o = {OP_LW, rs_i, rt_i, imm_i};
            KIND_SW:  word_o = {OP_SW, rs_i, rt_i, imm_i};
            KIND_BEQ: word_o = {OP_BEQ, rs_i, rt_i, imm_i};
            KIND_J:   word_o = {OP_J, target_i};
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: sequential program loader for instruction memory.
// Accepts a stream of instruction requests, encodes each one through
// mips_enc_word and writes the words to consecutive imem addresses starting
// at 0. A session is opened by start and closed by finish; the write
// pointer never wraps, so the session saturates once DEPTH words are in.
// Optional feature macro MIPS_ENC_NOP_PAD_EN: when defined, finish fills
// the remaining imem words with nops (32'h0) before returning to idle.
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              finish_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        req_kind_i,
    input  logic [4:0]        req_rs_i,
    input  logic [4:0]        req_rt_i,
    input  logic [4:0]        req_rd_i,
    input  logic [15:0]       req_imm_i,
    input  logic [25:0]       req_target_i,
    output logic              im_we_o,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic [31:0]       im_wdata_o,
    output logic              busy_o,
    output logic              full_o,
    output logic [ADDR_W:0]   count_o,
    output logic              err_illegal_o
);

    // Word count that marks imem as completely written
    localparam logic [ADDR_W:0]   DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    // Highest word address; the pointer parks here instead of wrapping
    localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};

    enc_state_e        state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic              full_q;
    logic              err_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic              reqReady;
    logic              handshake;
    logic              lastWord;
    logic [31:0]       encWord;
    logic              encIllegal;

    mips_enc_word u_enc_word (
        .kind_i    (req_kind_i),
        .rs_i      (req_rs_i),
        .rt_i      (req_rt_i),
        .rd_i      (req_rd_i),
        .imm_i     (req_imm_i),
        .target_i  (req_target_i),
        .word_o    (encWord),
        .illegal_o (encIllegal)
    );

    // Handshake qualification and the pointer/count values after one write
    always_comb begin
        reqReady  = (state_q == ST_LOAD) && !full_q && !start_i;
        handshake = req_valid_i && reqReady;
        ptr_d     = (ptr_q == PTR_MAX) ? ptr_q : ptr_q + ADDR_W'(1);
        count_d   = count_q + (ADDR_W + 1)'(1);
        lastWord  = (count_d == DEPTH_C);
    end

    // Session FSM together with the registered imem write port and status
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= 1'b0;
            if (start_i) begin
                state_q <= ST_LOAD;
                ptr_q   <= '0;
                count_q <= '0;
                full_q  <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    ST_LOAD: begin
                        if (handshake) begin
                            if (encIllegal) begin
                                err_q <= 1'b1;
                            end else begin
                                we_q    <= 1'b1;
                                addr_q  <= ptr_q;
                                wdata_q <= encWord;
                                ptr_q   <= ptr_d;
                                count_q <= count_d;
                                full_q  <= lastWord;
                            end
                        end
                        if (finish_i) begin
`ifdef MIPS_ENC_NOP_PAD_EN
                            if (full_q || (handshake && !encIllegal && lastWord)) begin
                                state_q <= ST_IDLE;
                            end else begin
                                state_q <= ST_PAD;
                            end
`else
                            state_q <= ST_IDLE;
`endif
                        end
                    end
`ifdef MIPS_ENC_NOP_PAD_EN
                    ST_PAD: begin
                        if (full_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            we_q    <= 1'b1;
                            addr_q  <= ptr_q;
                            wdata_q <= 32'h0000_0000;
                            ptr_q   <= ptr_d;
                            count_q <= count_d;
                            full_q  <= lastWord;
                            if (lastWord) begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
`endif
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign req_ready_o   = reqReady;
    assign im_we_o       = we_q;
    assign im_addr_o     = addr_q;
    assign im_wdata_o    = wdata_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign full_o        = full_q;
    assign count_o       = count_q;
    assign err_illegal_o = err_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder: scoreboard bench for the imem program loader.
// The driver predicts every imem write from a session-level model (words
// land at address "number of words written so far") and queues it; a
// negedge monitor pops and compares whenever im_we is seen. Honours
// MIPS_ENC_NOP_PAD_EN so the same bench covers both builds.
module tb_mips_instr_encoder;

    localparam int AW    = 3;
    localparam int DEPTH = 8;
`ifdef MIPS_ENC_NOP_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic          finish;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_kind;
    logic [4:0]    req_rs;
    logic [4:0]    req_rt;
    logic [4:0]    req_rd;
    logic [15:0]   req_imm;
    logic [25:0]   req_target;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          busy;
    logic          full;
    logic [AW:0]   count;
    logic          err_illegal;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cnt;
    } wr_t;

    wr_t expQ[$];
    int  assertCount = 0;
    int  failCount   = 0;

    // Session model: 0 = idle, 1 = loading, 2 = padding
    int  mState = 0;
    int  mCount = 0;
    bit  mErr   = 1'b0;

    mips_instr_encoder #(.ADDR_W(AW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .finish_i      (finish),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_kind_i    (req_kind),
        .req_rs_i      (req_rs),
        .req_rt_i      (req_rt),
        .req_rd_i      (req_rd),
        .req_imm_i     (req_imm),
        .req_target_i  (req_target),
        .im_we_o       (im_we),
        .im_addr_o     (im_addr),
        .im_wdata_o    (im_wdata),
        .busy_o        (busy),
        .full_o        (full),
        .count_o       (count),
        .err_illegal_o (err_illegal)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoding built from field positions with plain arithmetic
    function automatic logic [31:0] refWord(input int kind, input int rs, input int rt,
                                            input int rd, input int imm, input int target,
                                            output bit legal);
        int unsigned op;
        int unsigned fn;
        int unsigned regs;
        legal = 1'b1;
        op    = 0;
        fn    = 0;
        regs  = rs * (2 ** 21) + rt * (2 ** 16);
        case (kind)
            0: fn = 32;
            1: fn = 34;
            2: fn = 36;
            3: fn = 37;
            4: fn = 42;
            5: op = 35;
            6: op = 43;
            7: op = 4;
            8: op = 2;
            default: legal = 1'b0;
        endcase
        if (!legal)      return 32'd0;
        if (kind <= 4)   return 32'(regs + rd * (2 ** 11) + fn);
        if (kind == 8)   return 32'(op * (2 ** 26) + target);
        return 32'(op * (2 ** 26) + regs + imm);
    endfunction

    // Single comparison point: counts every check, reports each miss
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Status outputs against the model after the most recent edge
    task automatic checkState();
        checkOutput("busy", 32'(busy), 32'(mState != 0));
        checkOutput("count", 32'(count), 32'(mCount));
        checkOutput("full", 32'(full), 32'(mCount == DEPTH));
        checkOutput("err_illegal", 32'(err_illegal), 32'(mErr));
    endtask

    // One clock of stimulus: drive, check ready, advance the model
    task automatic applyStimulus(input bit st, input bit fin, input bit val, input int kind,
                                 input int rs, input int rt, input int rd, input int imm,
                                 input int target);
        bit          legal;
        bit          expReady;
        logic [31:0] w;
        @(posedge clk);
        #2;
        checkState();
        start      = st;
        finish     = fin;
        req_valid  = val;
        req_kind   = 4'(kind);
        req_rs     = 5'(rs);
        req_rt     = 5'(rt);
        req_rd     = 5'(rd);
        req_imm    = 16'(imm);
        req_target = 26'(target);
        #1;
        expReady = (mState == 1) && (mCount < DEPTH) && !st;
        checkOutput("req_ready", 32'(req_ready), 32'(expReady));
        w = refWord(kind, rs, rt, rd, imm, target, legal);
        if (st) begin
            mState = 1;
            mCount = 0;
            mErr   = 1'b0;
        end else if (mState == 1) begin
            if (val && expReady) begin
                if (legal) begin
                    expQ.push_back('{addr: mCount, data: w, cnt: mCount + 1});
                    mCount++;
                end else begin
                    mErr = 1'b1;
                end
            end
            if (fin) mState = (PAD_EN && mCount < DEPTH) ? 2 : 0;
        end else if (mState == 2) begin
            expQ.push_back('{addr: mCount, data: 32'h0, cnt: mCount + 1});
            mCount++;
            if (mCount == DEPTH) mState = 0;
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset pulse; outputs must clear without waiting for a clock
    task automatic applyReset();
        #1;
        start     = 1'b0;
        finish    = 1'b0;
        req_valid = 1'b0;
        rst       = 1'b1;
        #1;
        checkOutput("rst im_we", 32'(im_we), 32'd0);
        checkOutput("rst im_addr", 32'(im_addr), 32'd0);
        checkOutput("rst im_wdata", im_wdata, 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst full", 32'(full), 32'd0);
        checkOutput("rst count", 32'(count), 32'd0);
        checkOutput("rst err_illegal", 32'(err_illegal), 32'd0);
        checkOutput("rst req_ready", 32'(req_ready), 32'd0);
        expQ.delete();
        mState = 0;
        mCount = 0;
        mErr   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every imem write must match the oldest predicted write
    always @(negedge clk) begin
        if (!rst && im_we) begin
            if (expQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_write: got addr %0d data 0x%08h, expected no write at %0t",
                         im_addr, im_wdata, $time);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                checkOutput("im_addr", 32'(im_addr), 32'(e.addr));
                checkOutput("im_wdata", im_wdata, e.data);
                checkOutput("count@write", 32'(count), 32'(e.cnt));
                checkOutput("full@write", 32'(full), 32'(e.cnt == DEPTH));
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test plan followed by a randomized session mix
    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        finish     = 1'b0;
        req_valid  = 1'b0;
        req_kind   = '0;
        req_rs     = '0;
        req_rt     = '0;
        req_rd     = '0;
        req_imm    = '0;
        req_target = '0;
        #2;
        checkOutput("reset im_we", 32'(im_we), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset count", 32'(count), 32'd0);
        checkOutput("reset req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Session 1: known words, illegal kind, then run into full
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 0, 1, 2, 3, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1, 6, 7, 5, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 5, 29, 8, 0, 4, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 7, 1, 2, 0, 16'hFFFF, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8, 0, 0, 0, 0, 26'h10);
        applyStimulus(1'b0, 1'b0, 1'b1, 12, 3, 3, 3, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 0, 4, 5, 6, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 3, 4, 5, 6, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4, 7, 8, 9, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 0, 1, 1, 1, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 6, 2, 2, 0, 12, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
        idleCycle();
        idleCycle();

        // Session 2: two words then finish (pads to the end if enabled)
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 6, 29, 31, 0, 16'h8000, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 2, 10, 11, 12, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) idleCycle();

        // Session 3: restart mid-session with a request pending
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 0, 1, 1, 1, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1, 2, 2, 2, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 2, 3, 3, 3, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 0, 9, 9, 9, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8, 0, 0, 0, 0, 26'h3FFFFFF);
        applyStimulus(1'b0, 1'b1, 1'b1, 3, 17, 18, 19, 0, 0);
        idleCycle();
        applyReset();
        idleCycle();
        idleCycle();

        // Randomized sessions with occasional restarts, finishes and resets
        for (int n = 0; n < 500; n++) begin
            bit st;
            bit fin;
            bit val;
            int kind;
            st   = ($urandom_range(0, 99) < 3) || (mState == 0 && $urandom_range(0, 9) == 0);
            fin  = $urandom_range(0, 99) < 6;
            val  = $urandom_range(0, 99) < 75;
            kind = ($urandom_range(0, 99) < 12) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
            applyStimulus(st, fin, val, kind, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                          int'($urandom_range(0, 31)), int'($urandom_range(0, 65535)),
                          int'($urandom_range(0, 32'h3FFFFFF)));
            if ($urandom_range(0, 199) == 0) applyReset();
        end

        for (int i = 0; i < 12; i++) idleCycle();
        @(negedge clk);
        #1;
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Sequential instruction encoder: the counterpart of the single-cycle control decoder. It takes a stream of instruction requests (kind plus register/immediate/target fields), packs each into a 32-bit MIPS word, and writes the words sequentially into instruction memory through a write port. It is the program-load path used by the test harness and boot loader to fill imem ahead of the core. It covers exactly the decoded subset: add, sub, and, or, slt, lw, sw, beq, j.

## Interface
Parameters
- ADDR_W, 8: imem word-address width; DEPTH = 2**ADDR_W words.

Ports
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; opens a load session, write pointer to 0.
- finish  in  1  one-cycle pulse; closes the session.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_kind  in  4  instruction kind (package constants).
- req_rs, req_rt, req_rd  in  5 each  register fields.
- req_imm  in  16  I-type immediate (lw/sw offset, beq word offset).
- req_target  in  26  J-type target.
- im_we  out  1  imem write strobe.
- im_addr  out  ADDR_W  imem word address.
- im_wdata  out  32  encoded word.
- busy  out  1  state is not IDLE.
- full  out  1  DEPTH words written in this session.
- count  out  ADDR_W+1  words written in this session, including pads.
- err_illegal  out  1  sticky flag: an unknown req_kind was accepted.

## Operation
- FSM states: IDLE, LOAD, PAD (PAD exists only with the macro).
- IDLE: start goes to LOAD, with ptr=0, count=0, full=0 and err_illegal cleared.
- LOAD: req_ready = !full && !start.
  - On each handshake, the word is encoded and registered into im_wdata/im_addr=ptr/im_we=1 for one cycle, then ptr and count increment.
- Encoding:
  - R-type: {6'b000000, rs, rt, rd, 5'b0, funct}.
  - lw/sw: {op, rs, rt, imm}.
  - beq: {6'b000100, rs, rt, imm}.
  - j: {6'b000010, target}.
- Illegal kind: the request is accepted (handshake completes), nothing is written, ptr is unchanged, and err_illegal is set.
- Full: when count reaches DEPTH, full=1 and req_ready=0. No wrap-around ever; ptr holds.
- finish in LOAD: goes to IDLE, or to PAD with the macro. A handshake in the same cycle is still accepted and written.
- start in LOAD or PAD: restarts the session, with ptr=0 and count=0. start beats finish, and req_ready is low in the start cycle.
- start in IDLE with finish high: start wins.
- finish in IDLE or PAD: ignored.
- Outputs in IDLE: im_we=0. count, full and err_illegal hold until the next start.

## Timing
- Reset values: req_ready=0, im_we=0, im_addr=0, im_wdata=0, busy=0, full=0, count=0, err_illegal=0, state IDLE.
- Handshake at edge N gives im_we=1 with the word during cycle N+1. Latency is one cycle and throughput is one word per cycle.
- busy rises the cycle after start and falls the cycle after the last write (LOAD exit or last pad).
- full and count update in the same cycle as the corresponding im_we.
- Reset mid-operation: any pending write is dropped and all outputs return to reset values immediately.

## Configuration
- MIPS_ENC_NOP_PAD_EN defined: finish enters PAD.
  - PAD writes 32'h00000000 (nop) at ptr each cycle until count==DEPTH, then goes to IDLE.
  - If already full, finish goes directly to IDLE.
- Undefined: the PAD state and its logic are absent, finish always goes to IDLE, and the rest of imem is untouched.

## Structure
- Shared package mips_isa_pkg holds:
  - opcodes R=000000, LW=100011, SW=101011, BEQ=000100, J=000010;
  - functs ADD=100000, SUB=100010, AND=100100, OR=100101, SLT=101010;
  - req_kind constants KIND_ADD=0, SUB=1, AND=2, OR=3, SLT=4, LW=5, SW=6, BEQ=7, J=8 (9..15 illegal);
  - the FSM state enum.
- One sub-module, mips_enc_word: combinational packer (kind and fields in, word and illegal out). The top-level module holds the FSM, pointer, counters and output registers.

## Test plan
- start, then add rs=1 rt=2 rd=3 -> im_we one cycle later, im_addr=0, im_wdata=0x00221820, count=1.
- Back-to-back sub 5,6,7 / lw rt=8 rs=29 imm=4 / beq 1,2,imm=0xFFFF / j 0x10 -> words 0x00C72822, 0x8FA80004, 0x1022FFFF, 0x08000010 at addresses 0..3 on consecutive cycles.
- ADDR_W=2: 5 requests held valid -> 4 writes, full=1, req_ready=0, 5th never accepted, im_addr never wraps.
- req_kind=12 accepted -> no im_we, err_illegal=1, next valid add written at the unchanged ptr.
- Macro on, ADDR_W=3: 2 writes then finish -> 6 nop writes at addresses 2..7, busy falls the cycle after, count=8. Macro off: same stimulus -> IDLE immediately, count=2.
- start asserted mid-session with req_valid high, and rst pulsed during PAD -> req_ready low that cycle and the next write lands at address 0; the reset pulse clears all outputs immediately with no further im_we.
